// File: rtl/tmds_rx_decoder.sv
// TMDS receive-channel decoder: bit-slip symbol alignment on control-token runs,
// then per-symbol decode to DE / control bits / 8-bit data byte.
module tmds_rx_decoder #(
  parameter int unsigned CTRL_RUN      = 8,
  parameter int unsigned SEARCH_WINDOW = 4096,
  parameter int unsigned LOCK_TIMEOUT  = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] sym_in,
  output logic       locked,
  output logic [3:0] slip_offset,
  output logic       de,
  output logic [1:0] ctrl,
  output logic [7:0] data
);
  localparam int unsigned RUN_W = $clog2(CTRL_RUN + 1);
  localparam int unsigned WIN_W = $clog2(SEARCH_WINDOW + 1);
  localparam int unsigned TO_W  = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(CTRL_RUN - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(SEARCH_WINDOW - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t           state;
  logic [9:0]       prev_word;
  logic [9:0]       aligned_q;
  logic [19:0]      shifted;
  logic [RUN_W-1:0] run_cnt;
  logic [WIN_W-1:0] win_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             skip;
  logic             is_tok;
  logic [1:0]       tok_ctrl;
  logic [7:0]       t;
  logic [7:0]       dec_byte;

  // prev_word holds the earlier-received bits, so it forms the low half
  always_comb shifted = {sym_in, prev_word} >> slip_offset;

  always_comb begin
    is_tok   = 1'b1;
    tok_ctrl = 2'b00;
    case (aligned_q)
      10'h354: tok_ctrl = 2'b00;
      10'h0AB: tok_ctrl = 2'b01;
      10'h154: tok_ctrl = 2'b10;
      10'h2AB: tok_ctrl = 2'b11;
      default: is_tok = 1'b0;
    endcase
  end

  always_comb begin
    t           = aligned_q[9] ? ~aligned_q[7:0] : aligned_q[7:0];
    dec_byte    = '0;
    dec_byte[0] = t[0];
    for (int unsigned i = 1; i < 8; i++)
      dec_byte[i] = aligned_q[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_word   <= '0;
      aligned_q   <= '0;
      state       <= SEARCH;
      locked      <= 1'b0;
      slip_offset <= '0;
      run_cnt     <= '0;
      win_cnt     <= '0;
      to_cnt      <= '0;
      skip        <= 1'b0;
      de          <= 1'b0;
      ctrl        <= '0;
      data        <= '0;
    end else begin
      prev_word <= sym_in;
      aligned_q <= shifted[9:0];

      if (state == SEARCH) begin
        de   <= 1'b0;
        ctrl <= '0;
        data <= '0;
      end else if (is_tok) begin
        de   <= 1'b0;
        ctrl <= tok_ctrl;
        data <= '0;
      end else begin
        de   <= 1'b1;
        data <= dec_byte;
      end

      case (state)
        SEARCH: begin
          skip <= 1'b0;
          if (win_cnt != '1) win_cnt <= win_cnt + WIN_W'(1);
          // skip marks the one symbol still aligned at the pre-slip offset
          if (skip || !is_tok) run_cnt <= '0;
          else if (run_cnt != '1) run_cnt <= run_cnt + RUN_W'(1);

          if (!skip && is_tok && run_cnt == RUN_LAST) begin
            state   <= LOCKED;
            locked  <= 1'b1;
            to_cnt  <= '0;
            run_cnt <= '0;
            win_cnt <= '0;
          end else if (win_cnt == WIN_LAST) begin
            slip_offset <= (slip_offset == 4'd9) ? 4'd0 : slip_offset + 4'd1;
            run_cnt     <= '0;
            win_cnt     <= '0;
            skip        <= 1'b1;
          end
        end
        LOCKED: begin
          if (is_tok) begin
            to_cnt <= '0;
          end else if (to_cnt == TO_LAST) begin
            state   <= SEARCH;
            locked  <= 1'b0;
            to_cnt  <= '0;
            run_cnt <= '0;
            win_cnt <= '0;
          end else if (to_cnt != '1) begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end
endmodule

// File: tb/tb_tmds_rx_decoder.sv
// Bench for tmds_rx_decoder: directed alignment/decode scenarios plus random streams,
// every cycle compared against a serial-bitstream reference model.
`timescale 1ns/1ps
module tb_tmds_rx_decoder;
  localparam int CTRL_RUN = 8;
  localparam int SW       = 32;
  localparam int LT       = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] sym_in = '0;
  logic       locked;
  logic [3:0] slip_offset;
  logic       de;
  logic [1:0] ctrl;
  logic [7:0] data;

  tmds_rx_decoder #(
    .CTRL_RUN     (CTRL_RUN),
    .SEARCH_WINDOW(SW),
    .LOCK_TIMEOUT (LT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sym_in     (sym_in),
    .locked     (locked),
    .slip_offset(slip_offset),
    .de         (de),
    .ctrl       (ctrl),
    .data       (data)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: counts tokens seen in a serial bitstream viewed through a
  // 10-bit window at the current offset.
  int m_prev = 0, m_al = 0, m_off = 0, m_run = 0, m_win = 0, m_to = 0;
  bit m_lock = 0, m_fresh = 0, m_de = 0;
  int m_ctrl = 0, m_data = 0;

  function automatic int tok_code(input int q);
    case (q)
      'h354: return 0;
      'h0AB: return 1;
      'h154: return 2;
      'h2AB: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic int ref_byte(input int q);
    int tt, x;
    tt = ((q >> 9) & 1) ? (~q & 'hFF) : (q & 'hFF);
    x  = (tt ^ (tt << 1)) & 'hFF;
    if (((q >> 8) & 1) == 0) x = ~x & 'hFF;
    return (x & 'hFE) | (tt & 1);
  endfunction

  function automatic logic [9:0] rotl10(input int w, input int n);
    int r;
    r = ((w << n) | (w >> (10 - n))) & 'h3FF;
    return r[9:0];
  endfunction

  task automatic model_step();
    int tc, nal;
    if (reset) begin
      m_prev = 0; m_al = 0; m_off = 0; m_run = 0; m_win = 0; m_to = 0;
      m_lock = 0; m_fresh = 0; m_de = 0; m_ctrl = 0; m_data = 0;
      return;
    end
    tc = tok_code(m_al);
    if (!m_lock) begin
      m_de = 0; m_ctrl = 0; m_data = 0;
    end else if (tc >= 0) begin
      m_de = 0; m_ctrl = tc; m_data = 0;
    end else begin
      m_de = 1; m_data = ref_byte(m_al);
    end
    nal = (((int'(sym_in) << 10) | m_prev) >> m_off) & 'h3FF;
    if (!m_lock) begin
      m_run = (tc >= 0 && !m_fresh) ? m_run + 1 : 0;
      m_fresh = 0;
      m_win++;
      if (m_run >= CTRL_RUN) begin
        m_lock = 1; m_to = 0; m_run = 0; m_win = 0;
      end else if (m_win >= SW) begin
        m_off = (m_off + 1) % 10; m_run = 0; m_win = 0; m_fresh = 1;
      end
    end else if (tc >= 0) begin
      m_to = 0;
    end else begin
      m_to++;
      if (m_to >= LT) begin
        m_lock = 0; m_run = 0; m_win = 0;
      end
    end
    m_prev = sym_in;
    m_al   = nal;
  endtask

  task automatic tick();
    logic [15:0] exp_v;
    @(posedge clk);
    model_step();
    @(negedge clk);
    exp_v = {m_lock, 4'(m_off), m_de, 2'(m_ctrl), 8'(m_data)};
    check("cycle", {16'h0, locked, slip_offset, de, ctrl, data}, {16'h0, exp_v});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_lock(input int bound, output int n);
    n = 0;
    while (!locked && n < bound) begin
      tick();
      n++;
    end
  endtask

  logic [9:0] toks [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

  initial begin
    int n, steps, last_off;
    bit steps_ok;
    do_reset();
    check("reset_state", {locked, slip_offset, de, ctrl, data}, '0);

    // steady 0x354 at offset 0
    sym_in = 10'h354;
    wait_lock(40, n);
    check("lock354", locked, 1);
    check("lock354_within_budget", (n <= CTRL_RUN + 3), 1);
    check("lock354_off", slip_offset, 0);
    tick(); tick();
    check("lock354_ctrl", {de, ctrl}, 3'b000);

    // data decode, 3-cycle latency
    sym_in = 10'h100; tick(); sym_in = 10'h354; tick(); tick();
    check("data100", {de, data}, {1'b1, 8'h00});
    sym_in = 10'h2FF; tick(); sym_in = 10'h354; tick(); tick();
    check("data2ff", {de, data}, {1'b1, 8'hFE});
    tick(); tick();

    // timeout on data-only stream
    sym_in = 10'h100;
    for (int i = 0; i < LT + 4; i++) tick();
    check("timeout_unlock", locked, 0);
    check("timeout_forced", {de, ctrl, data}, 11'h0);
    check("timeout_off", slip_offset, 0);
    sym_in = 10'h354;
    wait_lock(40, n);
    check("relock", locked, 1);

    // 7 tokens, one data word, 7 tokens: no lock until the 8th consecutive token
    do_reset();
    for (int i = 0; i < 15; i++) begin
      sym_in = (i == 7) ? 10'h100 : 10'h354;
      tick();
    end
    sym_in = 10'h354;
    tick(); tick();
    check("run7_nolock", locked, 0);
    tick();
    check("run8_lock", locked, 1);

    // 0x0AB pre-shifted by 3 bits: offsets step 0,1,2,3
    do_reset();
    sym_in = rotl10('h0AB, 3);
    steps = 0; last_off = 0; steps_ok = 1; n = 0;
    while (!locked && n < 300) begin
      tick();
      n++;
      if (slip_offset != 4'(last_off)) begin
        if (slip_offset != 4'(last_off + 1)) steps_ok = 0;
        steps++;
        last_off = slip_offset;
      end
    end
    check("slip_lock", locked, 1);
    check("slip_final_off", slip_offset, 3);
    check("slip_steps", steps, 3);
    check("slip_monotonic", steps_ok, 1);
    tick(); tick();
    check("slip_ctrl", {de, ctrl}, 3'b001);
    for (int i = 0; i < 100; i++) tick();
    check("slip_stable", {locked, slip_offset}, 5'h13);

    // lock at offset 5, then a single reset cycle
    do_reset();
    sym_in = rotl10('h354, 5);
    wait_lock(500, n);
    check("off5_lock", {locked, slip_offset}, 5'h15);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset_after_lock", {locked, slip_offset, de, ctrl, data}, '0);

    // random streams: rotated token runs mixed with garbage and data-only bursts
    do_reset();
    for (int b = 0; b < 30; b++) begin
      int rot, pct;
      rot = $urandom_range(9, 0);
      pct = (b % 5 == 4) ? 0 : $urandom_range(100, 70);
      for (int i = 0; i < 80; i++) begin
        if ($urandom_range(99, 0) < pct) sym_in = rotl10(toks[$urandom_range(3, 0)], rot);
        else sym_in = 10'($urandom_range(1023, 0));
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
